// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ReqI = 1'b0,
    ReqD = 1'b1
  } req_id_e;

  localparam logic [31:0] ErrDataDefault = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Saturating watchdog counter: cleared on a new transaction, advanced while one is outstanding.
module arb_timeout_ctr #(
  parameter int unsigned Timeout = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one variable-latency memory port.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned   AW         = 32,
  parameter int unsigned   DW         = 32,
  parameter int unsigned   MAX_STREAK = 4,
  parameter int unsigned   TIMEOUT    = 64,
  parameter logic [DW-1:0] ERR_DATA   = DW'(ErrDataDefault)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          dm_stall,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          err_timeout
);

  localparam int unsigned StreakW = $clog2(MAX_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_STREAK);

  arb_state_e       state_q, state_d;
  logic             m_req_q, m_req_d, m_we_q, m_we_d;
  logic [AW-1:0]    m_addr_q, m_addr_d;
  logic [DW-1:0]    m_wdata_q, m_wdata_d;
  logic [DW-1:0]    if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d, rdata_sel;
  logic             if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
  logic             err_q, err_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic             grant_d, grant_i;
  logic             ctr_clr, ctr_en, ctr_expired;
  req_id_e          busy_id;

  arb_timeout_ctr #(
    .Timeout(TIMEOUT)
  ) u_timeout (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (ctr_clr),
    .en_i     (ctr_en),
    .expired_o(ctr_expired)
  );

  assign busy_id = (state_q == StBusyD) ? ReqD : ReqI;

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    err_d      = err_q;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    ctr_clr    = 1'b0;
    ctr_en     = 1'b0;
    rdata_sel  = m_rdata;

    unique case (state_q)
      StIdle: begin
        // Data belongs to the older instruction, unless fetch has waited out a full streak.
        if (dm_req && !(if_req && streak_q == StreakMax)) begin
          grant_d   = 1'b1;
          state_d   = StBusyD;
          m_req_d   = 1'b1;
          m_we_d    = dm_we;
          m_addr_d  = dm_addr;
          m_wdata_d = dm_wdata;
          ctr_clr   = 1'b1;
        end else if (if_req) begin
          grant_i   = 1'b1;
          state_d   = StBusyI;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
          ctr_clr   = 1'b1;
        end
      end
      StBusyI, StBusyD: begin
        ctr_en = 1'b1;
        if (m_ready || ctr_expired) begin
          m_req_d   = 1'b0;
          state_d   = StDone;
          rdata_sel = m_ready ? m_rdata : ERR_DATA;
          if (!m_ready) err_d = 1'b1;
          if (busy_id == ReqI) begin
            if_valid_d = 1'b1;
            if_rdata_d = rdata_sel;
          end else begin
            dm_valid_d = 1'b1;
            if (!m_we_q || !m_ready) dm_rdata_d = rdata_sel;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    streak_d = streak_q;
    if (!if_req || grant_i) begin
      streak_d = '0;
    end else if (grant_d && streak_q != StreakMax) begin
      streak_d = streak_q + StreakW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      err_q      <= 1'b0;
      streak_q   <= '0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      err_q      <= err_d;
      streak_q   <= streak_d;
    end
  end

  assign m_req       = m_req_q;
  assign m_we        = m_we_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign if_valid    = if_valid_q;
  assign dm_valid    = dm_valid_q;
  assign err_timeout = err_q;
  assign if_stall    = if_req & ~if_valid_q;
  assign dm_stall    = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single accesses plus multi-cycle corner cases.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_valid, dm_stall;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        m_req, m_we, m_ready, err_timeout;
  logic [31:0] m_addr, m_wdata, m_rdata;

  // Memory responder: m_ready pulses mem_lat cycles after m_req first appears (<0 = never).
  int          mem_lat;
  logic [31:0] mem_data;
  logic        auto_ready, man_ready;
  int          resp_cnt;

  assign m_ready = auto_ready | man_ready;
  assign m_rdata = mem_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(32), .DW(32), .MAX_STREAK(4), .TIMEOUT(64), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err_timeout(err_timeout)
  );

  initial begin
    auto_ready = 1'b0;
    resp_cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!m_req || rst) begin
        resp_cnt   = 0;
        auto_ready = 1'b0;
      end else begin
        resp_cnt++;
        auto_ready = (mem_lat >= 0) && (resp_cnt == mem_lat + 1);
      end
    end
  end

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          lat;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;
  } vec_t;

  vec_t vecs[5];
  vec_t v;
  int   npass = 0;
  int   ntotal = 0;
  int   cyc, n, busy, dgrants;
  bit   got, fseen, prev, stall_ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 0, 32'h40,  32'h0,        32'h8C220004, 2, 32'h8C220004, 32'h0};
    vecs[1] = '{1, 1, 32'h100, 32'h12345678, 32'h55555555, 1, 32'h8C220004, 32'h0};
    vecs[2] = '{1, 0, 32'h104, 32'h0,        32'hCAFEF00D, 0, 32'h8C220004, 32'hCAFEF00D};
    vecs[3] = '{1, 1, 32'h108, 32'hA5A5A5A5, 32'h11111111, 3, 32'h8C220004, 32'hCAFEF00D};
    vecs[4] = '{0, 0, 32'h44,  32'h0,        32'h00000013, 0, 32'h00000013, 32'hCAFEF00D};

    rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    man_ready = 1'b0; mem_lat = -1; mem_data = 32'h0;
    tick(); tick();
    check("rst_m_req", m_req, 0);
    check("rst_m_we", m_we, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_dm_valid", dm_valid, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_err", err_timeout, 0);
    rst = 1'b0;
    tick();
    check("idle_m_req", m_req, 0);

    // Table-driven single accesses
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      mem_lat  = v.lat;
      mem_data = v.mdata;
      if (v.is_data) begin
        dm_req = 1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
        if_req = 1; if_addr = v.addr;
      end
      #1;
      check($sformatf("v%0d_stall_on", i), v.is_data ? dm_stall : if_stall, 1);
      cyc = 0; got = 0;
      while (!got && cyc < 50) begin
        tick();
        cyc++;
        if (cyc == 1) begin
          check($sformatf("v%0d_m_req", i), m_req, 1);
          check($sformatf("v%0d_m_addr", i), m_addr, v.addr);
          check($sformatf("v%0d_m_we", i), m_we, v.is_data ? v.we : 1'b0);
          if (v.is_data && v.we) check($sformatf("v%0d_m_wdata", i), m_wdata, v.wdata);
        end
        got = v.is_data ? dm_valid : if_valid;
      end
      check($sformatf("v%0d_latency", i), cyc, v.lat + 2);
      check($sformatf("v%0d_other_valid", i), v.is_data ? if_valid : dm_valid, 0);
      check($sformatf("v%0d_stall_off", i), v.is_data ? dm_stall : if_stall, 0);
      check($sformatf("v%0d_if_rdata", i), if_rdata, v.exp_if_rdata);
      check($sformatf("v%0d_dm_rdata", i), dm_rdata, v.exp_dm_rdata);
      if_req = 0; dm_req = 0; dm_we = 0;
      tick();
      check($sformatf("v%0d_pulse_end", i), v.is_data ? dm_valid : if_valid, 0);
      check($sformatf("v%0d_m_req_low", i), m_req, 0);
    end

    // Simultaneous requests: data first, fetch only after DONE
    mem_lat = 1; mem_data = 32'h0BADF00D;
    dm_req = 1; dm_we = 0; dm_addr = 32'h200; if_req = 1; if_addr = 32'h80;
    tick();
    check("sim_first_addr", m_addr, 32'h200);
    n = 0; stall_ok = 1;
    while (!dm_valid && n < 20) begin
      if (!if_stall) stall_ok = 0;
      tick();
      n++;
    end
    check("sim_dm_valid", dm_valid, 1);
    check("sim_dm_rdata", dm_rdata, 32'h0BADF00D);
    check("sim_if_valid_low", if_valid, 0);
    dm_req = 0;
    #1;
    if (!if_stall) stall_ok = 0;
    tick();
    check("sim_no_grant_in_done", m_req, 0);
    if (!if_stall) stall_ok = 0;
    tick();
    check("sim_fetch_grant", m_req, 1);
    check("sim_fetch_addr", m_addr, 32'h80);
    check("sim_fetch_we", m_we, 0);
    check("sim_if_stall_held", stall_ok, 1);
    n = 0;
    while (!if_valid && n < 20) begin tick(); n++; end
    check("sim_if_rdata", if_rdata, 32'h0BADF00D);
    if_req = 0;
    tick();

    // Starvation guard: four data grants, then fetch
    mem_lat = 0; mem_data = 32'h00000077;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300; if_req = 1; if_addr = 32'h90;
    dgrants = 0; fseen = 0; prev = 0; n = 0;
    while (!fseen && n < 60) begin
      tick();
      n++;
      if (m_req && !prev) begin
        if (m_addr == 32'h90) fseen = 1;
        else dgrants++;
      end
      prev = m_req;
    end
    check("stv_fetch_seen", fseen, 1);
    check("stv_data_grants", dgrants, 4);
    check("stv_streak_clr", 32'(dut.streak_q), 0);
    n = 0;
    while (!if_valid && n < 20) begin tick(); n++; end
    check("stv_if_rdata", if_rdata, 32'h00000077);
    if_req = 0; dm_req = 0;
    tick(); tick();

    // Timeout on a hung memory
    mem_lat = -1;
    dm_req = 1; dm_we = 0; dm_addr = 32'h400;
    busy = 0; n = 0;
    while (!dm_valid && n < 100) begin
      tick();
      n++;
      if (m_req) busy++;
    end
    check("to_busy_cycles", busy, 64);
    check("to_dm_valid", dm_valid, 1);
    check("to_m_req_low", m_req, 0);
    check("to_rdata", dm_rdata, 32'hDEADBEEF);
    check("to_err", err_timeout, 1);
    dm_req = 0;
    tick(); tick();
    check("to_err_sticky", err_timeout, 1);
    check("to_pulse_end", dm_valid, 0);

    // Reset mid-access, then a stray m_ready
    dm_req = 1; dm_we = 0; dm_addr = 32'h500;
    tick();
    check("rm_busy", m_req, 1);
    rst = 1; dm_req = 0;
    tick();
    check("rm_m_req", m_req, 0);
    check("rm_err_clr", err_timeout, 0);
    rst = 0; man_ready = 1; mem_data = 32'h99999999;
    tick();
    man_ready = 0;
    check("rm_no_valid", dm_valid, 0);
    check("rm_m_req_idle", m_req, 0);
    check("rm_dm_rdata", dm_rdata, 0);
    tick();
    check("rm_no_valid2", dm_valid, 0);
    check("rm_state_idle", 32'(dut.state_q), 32'(StIdle));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between instruction fetch (read-only) and the data-memory stage (read/write).
- Sequences each access with a registered request/ready handshake.
- Returns data plus a one-cycle valid pulse to the winning requester, and drives per-requester stall signals used by the pipeline hazard logic.
- Data accesses have priority, since they belong to the older instruction. A streak limiter prevents fetch starvation, and a timeout guard recovers from a hung memory.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_STREAK, 4, consecutive data grants allowed while a fetch is pending
- TIMEOUT, 64, maximum cycles in BUSY before forced completion
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_valid
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched instruction; valid when if_valid=1
- if_valid  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req & ~if_valid, combinational
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_valid
- dm_we  in  1  1=write, 0=read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_rdata  out  DW  read data; valid when dm_valid=1 and dm_we=0
- dm_valid  out  1  one-cycle completion pulse for data
- dm_stall  out  1  dm_req & ~dm_valid, combinational
- m_req  out  1  memory request, registered
- m_we  out  1  memory write enable, registered
- m_addr  out  AW  memory address, registered
- m_wdata  out  DW  memory write data, registered
- m_rdata  in  DW  memory read data, sampled when m_ready=1
- m_ready  in  1  memory completion, one-cycle pulse
- err_timeout  out  1  sticky timeout flag, cleared only by rst

Behaviour:

Reset values (next edge with rst=1):
- State=IDLE.
- m_req=0, m_we=0, m_addr=0, m_wdata=0.
- if_valid=dm_valid=0, if_rdata=dm_rdata=0.
- Streak counter and timeout counter=0; err_timeout=0.
- Reset mid-access: the outstanding memory transaction is abandoned. An m_ready arriving in IDLE is ignored.

FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE, grant rule: if dm_req and not (if_req and streak==MAX_STREAK) -> BUSY_D; else if if_req -> BUSY_I; else stay.
- On a grant: register m_req=1, m_addr, m_we (0 for fetch), m_wdata; clear the timeout counter.
- BUSY_x: hold m_* stable and increment the timeout counter.
  - m_ready=1: capture m_rdata into the granted requester's rdata, assert its valid next cycle, drop m_req, go to DONE.
  - Counter reaches TIMEOUT-1 with no m_ready: drop m_req, rdata=ERR_DATA, set err_timeout=1, valid pulse, go to DONE.
- DONE: valid high for exactly this cycle. No new grant (the completed requester's req is still visible). Go to IDLE.

Streak counter (saturating at MAX_STREAK):
- Increments on each data grant made while if_req=1.
- Clears on a fetch grant, or on any cycle with if_req=0.

Latency and throughput:
- Request seen in IDLE at cycle 0 -> m_req=1 at cycle 1.
- m_ready at cycle k -> valid at cycle k+1.
- Next grant decision at cycle k+2.
- Minimum access = 3 cycles (m_ready at cycle 1).

Boundaries:
- Both requesting in IDLE: data wins unless the streak is saturated.
- m_ready outside BUSY: ignored.
- A write returns dm_valid; dm_rdata is unchanged.
- rdata outputs hold their last captured value between completions.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2, DONE=2'd3)
  - requester-id constants (REQ_I, REQ_D)
  - ERR_DATA default
- Sub-module arb_timeout_ctr: clear/enable/expired counter parameterised by TIMEOUT, reusable by other bus masters.
- Grant logic and FSM remain in mem_port_arbiter.

Test Plan:
- Single fetch: if_req=1, if_addr=0x40; memory asserts m_ready 2 cycles after m_req with m_rdata=0x8C220004 -> m_addr=0x40, m_we=0; if_valid one cycle with if_rdata=0x8C220004; if_stall=1 until that cycle.
- Data write: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0x12345678 -> m_we=1, m_wdata=0x12345678; dm_valid pulse; dm_rdata unchanged.
- Simultaneous requests, both issued in the same cycle -> data is granted first; fetch is granted only after the DONE cycle; if_stall stays high throughout.
- Starvation guard: dm_req continuously asserted with if_req=1, MAX_STREAK=4 -> exactly 4 data grants, then a fetch grant, then the streak counter returns to 0.
- Timeout: m_ready never asserted, TIMEOUT=64 -> m_req drops after 64 BUSY cycles; valid pulse with rdata=0xDEADBEEF; err_timeout stays 1 until rst.
- Reset mid-operation: rst in BUSY_D, then m_ready the next cycle -> m_req=0 after the reset edge; no dm_valid; state remains IDLE.
